// File: rtl/rtc_seq_pkg.sv
// Shared definitions for the RTC register-write sequencer: FSM state
// encoding, counter width and the strobe timing points (in counter ticks).
package rtc_seq_pkg;

  localparam int CNT_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIR  = 2'd1,
    DATO = 2'd2,
    FIN  = 2'd3
  } estado_t;

  // Address phase
  localparam logic [CNT_W-1:0] T_CS_A_ON  = 9'd10;
  localparam logic [CNT_W-1:0] T_WR_A_ON  = 9'd20;
  localparam logic [CNT_W-1:0] T_WR_A_OFF = 9'd110;
  localparam logic [CNT_W-1:0] T_CS_A_OFF = 9'd120;
  // Data phase
  localparam logic [CNT_W-1:0] T_DATA     = 9'd150;
  localparam logic [CNT_W-1:0] T_CS_D_ON  = 9'd160;
  localparam logic [CNT_W-1:0] T_WR_D_ON  = 9'd170;
  localparam logic [CNT_W-1:0] T_WR_D_OFF = 9'd260;
  localparam logic [CNT_W-1:0] T_CS_D_OFF = 9'd270;
  // End of transfer; the downstream counter tops out just above this
  localparam logic [CNT_W-1:0] T_END      = 9'd290;

  // Half-open strobe window [on, off) in counter ticks
  typedef struct packed {
    logic [CNT_W-1:0] on;
    logic [CNT_W-1:0] off;
  } ventana_t;

  function automatic ventana_t ventana_cs(input logic fase_dato);
    ventana_t v;
    v.on  = fase_dato ? T_CS_D_ON  : T_CS_A_ON;
    v.off = fase_dato ? T_CS_D_OFF : T_CS_A_OFF;
    return v;
  endfunction

  function automatic ventana_t ventana_wr(input logic fase_dato);
    ventana_t v;
    v.on  = fase_dato ? T_WR_D_ON  : T_WR_A_ON;
    v.off = fase_dato ? T_WR_D_OFF : T_WR_A_OFF;
    return v;
  endfunction

endpackage

// File: rtl/ventana_pulso.sv
// Registered window comparator: drives an active-low strobe that is low
// one cycle after cuenta enters [t_on, t_off) while activo is high.
module ventana_pulso
  import rtc_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       activo,
  input  logic [8:0] cuenta,
  input  logic [8:0] t_on,
  input  logic [8:0] t_off,
  output logic       pulso_n
);

  // Strobe register: low only while the count sits inside the window
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (reset) begin
      pulso_n <= 1'b1;
    end else begin
      pulso_n <= !(activo && (cuenta >= t_on) && (cuenta < t_off));
    end
  end

endmodule

// File: rtl/secuenciador_escritura_rtc.sv
// Control FSM for one RTC register transfer over a multiplexed A/D bus.
// Enables the downstream cycle counter, decodes its count into cs_n/wr_n
// strobes for an address phase followed by a data phase, and reports
// ocupado plus a one-cycle listo pulse.
// Optional build macro RTC_LECTURA_EN adds read transfers (leer, rd_n,
// bus_in, dato_leido); without it the block is write-only.
module secuenciador_escritura_rtc
  import rtc_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic [7:0] dir_in,
  input  logic [7:0] dato_in,
  input  logic [8:0] cuenta,
  output logic       en_cuenta,
  output logic       cs_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       ocupado,
  output logic       listo
`ifdef RTC_LECTURA_EN
  ,
  input  logic       leer,
  output logic       rd_n,
  input  logic [7:0] bus_in,
  output logic [7:0] dato_leido
`endif
);

  estado_t    estado_q, estado_d;
  logic [7:0] dir_q, dir_d;
  logic [7:0] dato_q, dato_d;
  logic       lectura_d;
  logic       fase_activa, fase_dato;
  ventana_t   v_cs, v_wr;
  logic       wr_win_n;

`ifdef RTC_LECTURA_EN
  logic lectura_q;
  logic es_rd_q;
  logic rd_n_q;
`endif

  // State register and operands latched at the accepted inicio
  always_ff @(posedge clk) begin
    // NOTE: operand registers are reset too, so bus_out never shows stale data after reset.
    if (reset) begin
      estado_q <= IDLE;
      dir_q    <= 8'h00;
      dato_q   <= 8'h00;
    end else begin
      estado_q <= estado_d;
      dir_q    <= dir_d;
      dato_q   <= dato_d;
    end
  end

  // Next-state logic; operands load only when a transfer is accepted
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    estado_d = estado_q;
    dir_d    = dir_q;
    dato_d   = dato_q;
`ifdef RTC_LECTURA_EN
    lectura_d = lectura_q;
`else
    lectura_d = 1'b0;
`endif
    case (estado_q)
      IDLE: begin
        if (inicio) begin
          estado_d = DIR;
          dir_d    = dir_in;
          dato_d   = dato_in;
`ifdef RTC_LECTURA_EN
          lectura_d = leer;
`endif
        end
      end
      DIR:     if (cuenta >= T_DATA) estado_d = DATO;
      // >= rather than == so a saturated or skipping counter still ends the phase
      DATO:    if (cuenta >= T_END)  estado_d = FIN;
      FIN:     estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  // Output registers loaded from the next state, so they switch with the FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      en_cuenta <= 1'b0;
      a_d       <= 1'b0;
      bus_out   <= 8'h00;
      bus_oe    <= 1'b0;
      ocupado   <= 1'b0;
      listo     <= 1'b0;
    end else begin
      en_cuenta <= (estado_d == DIR) || (estado_d == DATO);
      a_d       <= (estado_d == DATO);
      bus_out   <= (estado_d == DIR)  ? dir_d  :
                   (estado_d == DATO) ? dato_d : 8'h00;
      bus_oe    <= (estado_d == DIR) || ((estado_d == DATO) && !lectura_d);
      ocupado   <= (estado_d != IDLE);
      listo     <= (estado_d == FIN);
    end
  end

  // Phase selects which set of window limits the comparators use
  assign fase_activa = (estado_q == DIR) || (estado_q == DATO);
  assign fase_dato   = (estado_q == DATO);
  assign v_cs        = ventana_cs(fase_dato);
  assign v_wr        = ventana_wr(fase_dato);

  ventana_pulso u_ventana_cs (
    .clk     (clk),
    .reset   (reset),
    .activo  (fase_activa),
    .cuenta  (cuenta),
    .t_on    (v_cs.on),
    .t_off   (v_cs.off),
    .pulso_n (cs_n)
  );

  ventana_pulso u_ventana_wr (
    .clk     (clk),
    .reset   (reset),
    .activo  (fase_activa),
    .cuenta  (cuenta),
    .t_on    (v_wr.on),
    .t_off   (v_wr.off),
    .pulso_n (wr_win_n)
  );

`ifdef RTC_LECTURA_EN
  // Read bookkeeping: steer the shared strobe to rd_n during a read data
  // phase and capture the bus as rd_n returns high
  always_ff @(posedge clk) begin
    if (reset) begin
      lectura_q  <= 1'b0;
      es_rd_q    <= 1'b0;
      rd_n_q     <= 1'b1;
      dato_leido <= 8'h00;
    end else begin
      lectura_q <= lectura_d;
      // Registered on the same edge as the strobe so the steering lines up with it
      es_rd_q   <= fase_dato && lectura_q;
      rd_n_q    <= rd_n;
      if (rd_n && !rd_n_q) dato_leido <= bus_in;
    end
  end

  assign wr_n = wr_win_n | es_rd_q;
  assign rd_n = wr_win_n | ~es_rd_q;
`else
  assign wr_n = wr_win_n;
`endif

endmodule

// File: tb/tb_secuenciador_escritura_rtc.sv
// Self-checking bench for secuenciador_escritura_rtc. A behavioural counter
// feeds cuenta; a scoreboard queue holds the expected transfer and a monitor
// measures the strobe windows cycle by cycle, judging them at listo.
`timescale 1ns/1ps
module tb_secuenciador_escritura_rtc;

  localparam int CS_A_ON = 10,  WR_A_ON = 20,  WR_A_OFF = 110, CS_A_OFF = 120;
  localparam int DATA_AT = 150;
  localparam int CS_D_ON = 160, WR_D_ON = 170, WR_D_OFF = 260, CS_D_OFF = 270;
  localparam int END_AT  = 290;
  localparam int W_CSA = 0, W_WRA = 1, W_CSD = 2, W_WRD = 3, W_RDD = 4;

  logic       clk = 1'b0;
  logic       reset, inicio;
  logic [7:0] dir_in, dato_in;
  logic [8:0] cuenta = 9'd0;
  logic [8:0] cnt_prev = 9'd0;
  logic       en_cuenta, cs_n, wr_n, a_d, bus_oe, ocupado, listo;
  logic [7:0] bus_out;
  bit         sat_mode = 1'b0;
`ifdef RTC_LECTURA_EN
  logic       leer, rd_n;
  logic [7:0] bus_in, dato_leido;
`endif

  typedef struct {
    logic [7:0] dir;
    logic [7:0] dato;
    bit         lect;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Window statistics collected by the monitor for the running transfer
  int   w_lo[5], w_hi[5], w_n[5];
  int   ad_first, bus_err, guard_err, oe_err, en_err, wr_out;
  logic prev_cs_n = 1'b1, prev_a_d = 1'b0;
  logic [7:0] prev_bus = 8'h00;

  secuenciador_escritura_rtc dut (
    .clk       (clk),
    .reset     (reset),
    .inicio    (inicio),
    .dir_in    (dir_in),
    .dato_in   (dato_in),
    .cuenta    (cuenta),
    .en_cuenta (en_cuenta),
    .cs_n      (cs_n),
    .wr_n      (wr_n),
    .a_d       (a_d),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .ocupado   (ocupado),
    .listo     (listo)
`ifdef RTC_LECTURA_EN
    ,
    .leer       (leer),
    .rd_n       (rd_n),
    .bus_in     (bus_in),
    .dato_leido (dato_leido)
`endif
  );

  always #5 clk = ~clk;

  // Downstream cycle counter: cleared while disabled, counts from 1 once
  // enabled, tops out at 291. In sat_mode it skips 290 and sticks at 291.
  always @(posedge clk) begin
    cnt_prev <= cuenta;
    if (!en_cuenta)                       cuenta <= 9'd0;
    else if (sat_mode && cuenta >= 9'd289) cuenta <= 9'd291;
    else if (cuenta < 9'd291)              cuenta <= cuenta + 9'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void clear_acc();
    for (int i = 0; i < 5; i++) begin
      w_lo[i] = 999; w_hi[i] = -1; w_n[i] = 0;
    end
    ad_first = -1; bus_err = 0; guard_err = 0; oe_err = 0; en_err = 0; wr_out = 0;
  endfunction

  function automatic void upd(input int w, input int c);
    if (c < w_lo[w]) w_lo[w] = c;
    if (c > w_hi[w]) w_hi[w] = c;
    w_n[w]++;
  endfunction

  task automatic check_win(input string name, input int w, input int on, input int off);
    check({name, " first count"}, w_lo[w], on);
    check({name, " last count"},  w_hi[w], off - 1);
    check({name, " length"},      w_n[w],  off - on);
  endtask

  // Monitor: samples on the falling edge; outputs reflect cnt_prev
  initial begin : monitor
    exp_t e;
    int   c;
    clear_acc();
    forever begin
      @(negedge clk);
      c = int'(cnt_prev);
      if (!ocupado) begin
        clear_acc();
      end else if (exp_q.size() == 0) begin
        if (listo) check("listo with no transfer pending", 1, 0);
      end else begin
        e = exp_q[0];
        if (!listo) begin
          if (en_cuenta !== 1'b1) en_err++;
          if (bus_oe !== !(a_d && e.lect)) oe_err++;
        end else if (en_cuenta !== 1'b0 || bus_oe !== 1'b0) begin
          en_err++;
        end
        if (a_d && ad_first < 0) ad_first = c;
        if (!cs_n) begin
          if (!a_d) begin
            upd(W_CSA, c);
            if (bus_out !== e.dir) bus_err++;
          end else begin
            upd(W_CSD, c);
            if (!e.lect && bus_out !== e.dato) bus_err++;
          end
        end
        if ((!cs_n || !prev_cs_n) && (a_d !== prev_a_d || bus_out !== prev_bus)) guard_err++;
        if (!wr_n) begin
          if (cs_n) wr_out++;
          upd(a_d ? W_WRD : W_WRA, c);
        end
`ifdef RTC_LECTURA_EN
        if (!rd_n) begin
          if (cs_n || !a_d) wr_out++;
          upd(W_RDD, c);
        end
`endif
        if (listo) begin
          e = exp_q.pop_front();
          check("listo after end count", c >= END_AT, 1);
          check_win("cs_n address", W_CSA, CS_A_ON, CS_A_OFF);
          check_win("wr_n address", W_WRA, WR_A_ON, WR_A_OFF);
          check_win("cs_n data",    W_CSD, CS_D_ON, CS_D_OFF);
          if (e.lect) check("wr_n data length on read", w_n[W_WRD], 0);
          else        check_win("wr_n data", W_WRD, WR_D_ON, WR_D_OFF);
`ifdef RTC_LECTURA_EN
          if (e.lect) check_win("rd_n data", W_RDD, WR_D_ON, WR_D_OFF);
          else        check("rd_n length on write", w_n[W_RDD], 0);
`endif
          check("a_d first count",        ad_first,  DATA_AT);
          check("bus_out value errors",   bus_err,   0);
          check("guard band violations",  guard_err, 0);
          check("bus_oe errors",          oe_err,    0);
          check("en_cuenta errors",       en_err,    0);
          check("strobe outside cs_n",    wr_out,    0);
        end
      end
      prev_cs_n = cs_n;
      prev_a_d  = a_d;
      prev_bus  = bus_out;
    end
  end

  // One transfer: push expectation, start it, optionally disturb it, wait for listo
  task automatic transferir(input logic [7:0] d, input logic [7:0] v, input bit lect,
                            input bit repulse, input bit sat, input bit abort);
    exp_t e;
    int   ciclos;
    int   listos;
    bit   visto;
    bit   abortado;
    @(negedge clk);
    check("ocupado low before inicio", ocupado, 0);
    check("listo low before inicio",   listo,   0);
    e.dir = d; e.dato = v; e.lect = lect;
    exp_q.push_back(e);
    sat_mode = sat;
    inicio = 1'b1; dir_in = d; dato_in = v;
`ifdef RTC_LECTURA_EN
    leer = lect;
`endif
    @(negedge clk);
    inicio = 1'b0;
    dir_in = 8'($urandom); dato_in = 8'($urandom);
    check("ocupado after inicio", ocupado, 1);
    ciclos = 0; visto = 1'b0; abortado = 1'b0;
    while (!visto && !abortado && ciclos < 600) begin
      inicio = (repulse && (cuenta == 9'd50 || cuenta == 9'd200));
      if (inicio) begin
        dir_in = 8'($urandom); dato_in = 8'($urandom);
      end
      if (abort && cuenta == 9'd180) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_back());
        check("abort cs_n",      cs_n,      1);
        check("abort wr_n",      wr_n,      1);
        check("abort en_cuenta", en_cuenta, 0);
        check("abort ocupado",   ocupado,   0);
        check("abort bus_oe",    bus_oe,    0);
        listos = 0;
        repeat (8) begin
          @(negedge clk);
          if (listo) listos++;
        end
        check("no listo after abort", listos, 0);
        abortado = 1'b1;
      end else begin
        @(negedge clk);
        ciclos++;
        if (listo) visto = 1'b1;
      end
    end
    inicio = 1'b0;
    if (!abortado) begin
      check("listo within bound", visto, 1);
      if (!visto) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
      end
    end
  endtask

  initial begin : stimulus
    int en_hi;
    reset = 1'b1; inicio = 1'b0; dir_in = 8'h00; dato_in = 8'h00;
`ifdef RTC_LECTURA_EN
    leer = 1'b0; bus_in = 8'hC3;
`endif
    repeat (3) @(negedge clk);
    check("reset en_cuenta", en_cuenta, 0);
    check("reset cs_n",      cs_n,      1);
    check("reset wr_n",      wr_n,      1);
    check("reset a_d",       a_d,       0);
    check("reset bus_out",   bus_out,   0);
    check("reset bus_oe",    bus_oe,    0);
    check("reset ocupado",   ocupado,   0);
    check("reset listo",     listo,     0);
    reset = 1'b0;
    en_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (en_cuenta) en_hi++;
    end
    check("en_cuenta idle cycles high", en_hi, 0);

    transferir(8'h21, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    transferir(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);  // back-to-back
    transferir(8'hA5, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);                // re-pulsed inicio
    transferir(8'h77, 8'h88, 1'b0, 1'b0, 1'b0, 1'b1);                // reset at count 180
    transferir(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    transferir(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);  // saturating counter
    for (int i = 0; i < 3; i++)
      transferir(8'($urandom), 8'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0);
`ifdef RTC_LECTURA_EN
    transferir(8'h4E, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    check("dato_leido after read", dato_leido, 8'hC3);
`endif
    repeat (5) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
